// File: rtl/seq_detect_1011_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_detect_1011_if                                              |
// | Brief    : Serial-bit input and detector status bundle for seq_detect_1011 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface seq_detect_1011_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 data_in;
    logic                 enable;
    logic                 detect;
    logic [CNT_WIDTH-1:0] match_count;
    logic [7:0]           history;
    logic [2:0]           state;

    modport master (
        output data_in,
        output enable,
        input  detect,
        input  match_count,
        input  history,
        input  state
    );

    modport slave (
        input  data_in,
        input  enable,
        output detect,
        output match_count,
        output history,
        output state
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_1011.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_detect_1011                                                 |
// | Brief    : Overlapping 1-0-1-1 detector with saturating match counter      |
// |            and 8-bit accepted-bit history                                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module seq_detect_1011 #(
    parameter int CNT_WIDTH = 8
) (
    input  wire logic            clock,
    input  wire logic            reset,
    seq_detect_1011_if.slave     bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S1    = 3'd1,
        S10   = 3'd2,
        S101  = 3'd3,
        S1011 = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

    state_t               r_state;
    logic                 r_detect;
    logic [CNT_WIDTH-1:0] r_match_count;
    logic [7:0]           r_history;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_detect      <= 1'b0;
            r_match_count <= '0;
            r_history     <= 8'h00;
        end else begin
            r_detect <= 1'b0;
            if (bus.enable) begin
                r_history <= {r_history[6:0], bus.data_in};
            end
            // Illegal encodings recover to IDLE whether or not a bit is accepted.
            case (r_state)
                IDLE: begin
                    if (bus.enable) r_state <= bus.data_in ? S1 : IDLE;
                end
                S1: begin
                    if (bus.enable) r_state <= bus.data_in ? S1 : S10;
                end
                S10: begin
                    if (bus.enable) r_state <= bus.data_in ? S101 : IDLE;
                end
                S101: begin
                    if (bus.enable) begin
                        if (bus.data_in) begin
                            r_state  <= S1011;
                            r_detect <= 1'b1;
                            if (r_match_count != c_cnt_max) begin
                                r_match_count <= r_match_count + CNT_WIDTH'(1);
                            end
                        end else begin
                            r_state <= S10;
                        end
                    end
                end
                S1011: begin
                    if (bus.enable) r_state <= bus.data_in ? S1 : S10;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.detect      = r_detect;
    assign bus.match_count = r_match_count;
    assign bus.history     = r_history;
    assign bus.state       = r_state;
endmodule
`default_nettype wire

// File: tb/tb_seq_detect_1011.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_detect_1011                                              |
// | Brief    : Scoreboard bench for seq_detect_1011 (8-bit and 2-bit counters) |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_seq_detect_1011;
    logic clock;
    logic reset;

    seq_detect_1011_if #(.CNT_WIDTH(8)) bus8 ();
    seq_detect_1011_if #(.CNT_WIDTH(2)) bus2 ();

    seq_detect_1011 #(.CNT_WIDTH(8)) dut8 (.clock(clock), .reset(reset), .bus(bus8));
    seq_detect_1011 #(.CNT_WIDTH(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       detect;
        logic [7:0] count8;
        logic [1:0] count2;
        logic [7:0] history;
        logic [2:0] state;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 0;

    // Reference model: the accepted-bit stream since the last reset.
    int   acc[$];
    int   m_count8;
    int   m_count2;
    logic m_detect;

    function automatic logic suffix_is_prefix(int k);
        int pat[4] = '{1, 0, 1, 1};
        if (acc.size() < k) return 1'b0;
        for (int i = 0; i < k; i++)
            if (acc[acc.size() - k + i] != pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        e.detect  = m_detect;
        e.count8  = 8'(m_count8);
        e.count2  = 2'(m_count2);
        e.history = 8'h00;
        for (int i = 0; i < 8; i++)
            if (i < acc.size()) e.history[i] = acc[acc.size() - 1 - i][0];
        e.state = 3'd0;
        for (int k = 4; k >= 1; k--) begin
            if (suffix_is_prefix(k)) begin
                e.state = 3'(k);
                break;
            end
        end
        return e;
    endfunction

    task automatic model_edge(input logic rst_n, input logic en, input logic d);
        if (!rst_n) begin
            acc.delete();
            m_count8 = 0;
            m_count2 = 0;
            m_detect = 1'b0;
        end else begin
            m_detect = 1'b0;
            if (en) begin
                acc.push_back(int'(d));
                if (acc.size() > 8) void'(acc.pop_front());
                if (suffix_is_prefix(4)) begin
                    m_detect = 1'b1;
                    if (m_count8 < 255) m_count8++;
                    if (m_count2 < 3) m_count2++;
                end
            end
        end
    endtask

    // Called at a falling edge: drive, predict, then return at the next falling edge.
    task automatic step(input logic rst_n, input logic en, input logic d);
        reset        = rst_n;
        bus8.enable  = en;
        bus2.enable  = en;
        bus8.data_in = d;
        bus2.data_in = d;
        model_edge(rst_n, en, d);
        exp_q.push_back(model_outputs());
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, bits[i]);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: one expected record per clock edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a.detect  = bus8.detect;
                a.count8  = bus8.match_count;
                a.count2  = bus2.match_count;
                a.history = bus8.history;
                a.state   = bus8.state;
                checks++;
                if (a !== e || bus2.detect !== e.detect || bus2.history !== e.history
                    || bus2.state !== e.state) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got det=%b/%b cnt=%0h/%0h hist=%h/%h st=%0d/%0d expected det=%b cnt=%0h/%0h hist=%h st=%0d",
                             $time, a.detect, bus2.detect, a.count8, a.count2, a.history,
                             bus2.history, a.state, bus2.state, e.detect, e.count8, e.count2,
                             e.history, e.state);
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        bus8.enable = 1'b0; bus8.data_in = 1'b0;
        bus2.enable = 1'b0; bus2.data_in = 1'b0;
        @(negedge clock);

        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("reset_detect",  32'(bus8.detect), 32'd0);
        chk("reset_count",   32'(bus8.match_count), 32'd0);
        chk("reset_history", 32'(bus8.history), 32'h00);
        chk("reset_state",   32'(bus8.state), 32'd0);

        feed(16'b1011, 4);
        chk("first_detect",  32'(bus8.detect), 32'd1);
        chk("first_count",   32'(bus8.match_count), 32'd1);
        chk("first_history", 32'(bus8.history), 32'h0B);
        chk("first_state",   32'(bus8.state), 32'd4);

        step(1'b0, 1'b1, 1'b1);
        feed(16'b1011011, 7);
        chk("overlap_count",   32'(bus8.match_count), 32'd2);
        chk("overlap_history", 32'(bus8.history), 32'h5B);

        step(1'b0, 1'b1, 1'b0);
        feed(16'b10, 2);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        chk("gap_state",   32'(bus8.state), 32'd2);
        chk("gap_history", 32'(bus8.history), 32'h02);
        feed(16'b11, 2);
        chk("gap_detect", 32'(bus8.detect), 32'd1);

        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) feed(16'b1011, 4);
        chk("sat_count2", 32'(bus2.match_count), 32'd3);
        chk("sat_count8", 32'(bus8.match_count), 32'd4);
        chk("sat_detect", 32'(bus2.detect), 32'd1);

        feed(16'b101, 3);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("post_reset_detect",  32'(bus8.detect), 32'd0);
        chk("post_reset_state",   32'(bus8.state), 32'd1);
        chk("post_reset_history", 32'(bus8.history), 32'h01);

        for (int i = 0; i < 400; i++)
            step(($urandom % 50) != 0, ($urandom % 4) != 0, 1'($urandom));

        stim_done = 1;
        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/seq_detect_1011.md
# seq_detect_1011

Serial pattern detector that consumes the single-bit stream produced by the lab's D flip-flop stage (its `data_out` drives this block's `data_in`). It recognises the overlapping pattern 1-0-1-1 in accepted bits, emits a one-cycle detect pulse, keeps a saturating match count, and exposes an 8-bit history of accepted bits for bench observation.

## Interface
- `CNT_WIDTH`, default 8: width of the saturating match counter.
- `clock`  input  1  rising-edge clock shared with the upstream flip-flop.
- `reset`  input  1  synchronous, active-low reset. Sampled on the rising edge of `clock`.
- `data_in`  input  1  serial bit from the upstream flip-flop.
- `enable`  input  1  when high, `data_in` is accepted on this edge; when low, all state holds.
- `detect`  output  1  registered one-cycle pulse per completed pattern.
- `match_count`  output  CNT_WIDTH  number of detections, saturating at all-ones.
- `history`  output  8  last 8 accepted bits; newest bit in bit 0.
- `state`  output  3  current FSM encoding, for debug.

## Operation
- FSM states and encodings: IDLE=0 (no prefix), S1=1 ("1"), S10=2 ("10"), S101=3 ("101"), S1011=4 (full match).
- Transitions on an accepted bit (enable=1), with overlap:
  - IDLE: 1→S1, 0→IDLE
  - S1: 0→S10, 1→S1
  - S10: 1→S101, 0→IDLE
  - S101: 1→S1011, 0→S10
  - S1011: 1→S1, 0→S10
- Encodings 5–7 are illegal; if they occur, the next edge goes to IDLE regardless of `enable`.
- `detect` is set on an edge where enable=1, state=S101, and data_in=1. It is cleared on every other edge, including edges with enable=0, so it never stretches beyond one cycle.
- `match_count` increments on the same edge that sets `detect`. At all-ones it holds; there is no wrap.
- `history`: on an accepted bit it becomes {history[6:0], data_in}; otherwise it holds.
- Reset (reset=0 at a rising edge) has priority over `enable`:
  - state ← IDLE
  - detect ← 0
  - match_count ← 0
  - history ← 8'h00
- Reset asserted mid-pattern discards all prefix progress. The first bit after reset release is treated as the first bit of a new stream.

## Timing
- All outputs are registered; nothing depends combinationally on inputs.
- Latency: the 4th pattern bit is accepted at edge k. `detect` is high from edge k to edge k+1. `match_count` shows the new value from edge k.
- `state` reflects the bit accepted at the previous edge.
- enable=0 cycles are invisible to pattern matching: 1,0,(gap),1,1 is a match.
- Back-to-back overlapping matches (1011011) give `detect` pulses separated by exactly 3 accepted bits.
- Simultaneous reset and match edge: reset wins, so detect=0 and count=0.
- The bench must change `data_in`/`enable` away from the rising edge, as the upstream flip-flop output does.

## Test plan
- Hold reset=0 for 2 edges with data_in=1, enable=1 → detect=0, match_count=0, history=8'h00, state=0.
- Release reset; feed 1,0,1,1 with enable=1 → detect high for exactly the cycle after the 4th edge, match_count=1, history=8'h0B, state=4.
- Feed 1,0,1,1,0,1,1 → two detect pulses, after bits 4 and 7; match_count=2; history=8'h5B.
- Feed 1,0, then 3 cycles of enable=0 with data_in=0, then 1,1 → one detect after the final bit; state and history are unchanged during the gap.
- With CNT_WIDTH=2, feed 1011 four times → match_count goes 1,2,3,3; detect still pulses on every match.
- Feed 1,0,1, pulse reset=0 for one edge, then feed 1 → no detect; state=1 and history=8'h01 after that bit.
